matrix_mem_ctrl: RTL and testbench

Initiator-side controller for the 16×8-bit matrix memory (128-bit word, `en`/`mode` access, registered read output). It assembles a byte stream into one 128-bit matrix word and issues a single write cycle. On request it issues a read cycle, captures the memory's registered output, and streams it back out as 16 bytes. It sits between the byte-serial datapath and the memory block, owning all `en`/`mode` sequencing.

---
 rtl/matrix_mem_ctrl.sv | 72 +++++++
 tb/tb_matrix_mem_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mem_ctrl.sv
// matrix_mem_ctrl: assembles a 16-byte stream into one 128-bit memory write and
// streams a registered 128-bit memory read back out byte by byte.
module matrix_mem_ctrl #(
  parameter int ELEM_W = 8,
  parameter int N_ELEM = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ELEM_W-1:0]          s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       rd_req,
  output logic [ELEM_W-1:0]          m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_last,
  output logic [ELEM_W*N_ELEM-1:0]   mem_wdata,
  output logic                       mem_en,
  output logic                       mem_mode,
  input  logic [ELEM_W*N_ELEM-1:0]   mem_rdata,
  output logic                       busy
);
  localparam int CW = $clog2(N_ELEM);
  localparam logic [CW-1:0] LAST = CW'(N_ELEM - 1);
  typedef enum logic [2:0] {LOAD, WRITE, READ, WAIT, SEND} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [ELEM_W*N_ELEM-1:0] data_buf;
  logic rd_go, s_hs, m_hs;
  assign rd_go = (state == LOAD) && (cnt == '0) && rd_req;
  assign s_hs = s_valid && s_ready;
  assign m_hs = m_valid && m_ready;
  assign mem_wdata = data_buf;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= LOAD;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    state_nxt = rd_go ? READ : (s_hs && cnt == LAST) ? WRITE : LOAD;
      WRITE:   state_nxt = LOAD;
      READ:    state_nxt = WAIT;
      WAIT:    state_nxt = SEND;
      SEND:    state_nxt = (m_hs && m_last) ? LOAD : SEND;
      default: state_nxt = LOAD;
    endcase
  end
  // s_ready is gated by rst so it reads 0 while reset is held
  always_comb begin
    s_ready  = rst && (state == LOAD) && !rd_go;
    mem_en   = (state == WRITE) || (state == READ);
    mem_mode = (state == WRITE);
    m_valid  = (state == SEND);
    m_last   = m_valid && (cnt == LAST);
    m_data   = m_valid ? data_buf[ELEM_W*cnt +: ELEM_W] : '0;
    busy     = !((state == LOAD) && (cnt == '0));
  end
  // mem_rdata is only valid in WAIT, the cycle after the READ strobe
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt      <= '0;
      data_buf <= '0;
    end else if (state == WAIT) begin
      cnt      <= '0;
      data_buf <= mem_rdata;
    end else if (s_hs) begin
      cnt                             <= cnt + 1'b1;
      data_buf[ELEM_W*cnt +: ELEM_W]  <= s_data;
    end else if (m_hs) begin
      cnt <= cnt + 1'b1;
    end
endmodule

// File: tb/tb_matrix_mem_ctrl.sv
// tb_matrix_mem_ctrl: scoreboard bench with a one-word registered memory model.
module tb_matrix_mem_ctrl;
  logic clk = 0, rst = 1;
  logic [7:0] s_data = 0, m_data;
  logic s_valid = 0, s_ready, rd_req = 0, m_valid, m_ready = 1, m_last;
  logic [127:0] mem_wdata, mem_rdata = 0, mem_word = 0;
  logic mem_en, mem_mode, busy;
  logic a5 = 0, rd_ok = 0, stall = 0, pl = 0;
  logic [7:0] pd = 0;
  logic [8:0] e;
  int checks = 0, failures = 0, n;
  logic [8:0] rq[$];
  logic [127:0] wq[$];

  matrix_mem_ctrl dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .rd_req(rd_req), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_mode(mem_mode),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && mem_mode) mem_word <= mem_wdata;
    mem_rdata <= (mem_en && !mem_mode) ? (a5 ? {16{8'hA5}} : mem_word) : '0;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (stall) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_data", m_data, pd);
      chk("hold_last", m_last, pl);
    end
    if (m_valid && m_ready) begin
      chk("rd_queue_nonempty", rq.size() != 0, 1);
      if (rq.size() != 0) begin
        e = rq.pop_front();
        chk("m_data", m_data, e[7:0]);
        chk("m_last", m_last, e[8]);
      end
    end
    if (mem_en && mem_mode) begin
      chk("wr_queue_nonempty", wq.size() != 0, 1);
      if (wq.size() != 0) chk("mem_wdata", mem_wdata, wq.pop_front());
    end
    if (mem_en && !mem_mode) chk("read_allowed", rd_ok, 1);
    stall = m_valid && !m_ready;
    pd = m_data;
    pl = m_last;
  end

  task automatic push_rd(input logic [127:0] w);
    for (int i = 0; i < 16; i++) rq.push_back({i == 15, w[8*i +: 8]});
  endtask

  task automatic load(input logic [127:0] w, input bit gaps, input int lo, input int hi);
    int t;
    for (int i = lo; i < hi; i++) begin
      if (gaps && i[0]) begin
        s_valid = 0;
        @(posedge clk); #1;
      end
      s_data = w[8*i +: 8];
      s_valid = 1;
      t = 0;
      @(negedge clk);
      while (!s_ready && t < 50) begin t++; @(negedge clk); end
      if (t == 50) chk("s_ready_timeout", s_ready, 1);
      @(posedge clk); #1;
    end
    s_valid = 0;
  endtask

  task automatic stream(input bit bp, output int cyc);
    cyc = 0;
    while (busy && cyc < 400) begin
      m_ready = bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    m_ready = 1;
    chk("stream_done", busy, 0);
  endtask

  task automatic rd(input logic [127:0] w, input bit bp, input bit timing);
    int c;
    push_rd(w);
    rd_ok = 1;
    rd_req = 1;
    @(posedge clk); #1;
    rd_req = 0;
    if (timing) begin
      chk("read_en", mem_en, 1);
      chk("read_mode", mem_mode, 0);
      @(posedge clk); #1;
      chk("wait_en", mem_en, 0);
      chk("wait_valid", m_valid, 0);
      @(posedge clk); #1;
      chk("first_valid", m_valid, 1);
    end
    stream(bp, c);
    if (timing) chk("stream_cycles", c, 16);
    rd_ok = 0;
  endtask

  initial begin
    #1 rst = 0;
    for (int i = 0; i < 5; i++) begin
      s_data = 8'($urandom); s_valid = 1'($urandom); rd_req = 1'($urandom); m_ready = 1'($urandom);
      @(negedge clk);
      chk("reset_outs", {s_ready, m_valid, m_last, m_data, mem_en, mem_mode, busy}, 0);
      chk("reset_wdata", mem_wdata, 0);
      @(posedge clk); #1;
    end
    s_valid = 0; rd_req = 0; m_ready = 1;
    rst = 1;
    @(negedge clk);
    chk("idle_ready", s_ready, 1);
    chk("idle_busy", busy, 0);
    @(posedge clk); #1;

    // write 00..0F then read it back with exact timing
    wq.push_back(128'h0F0E0D0C0B0A09080706050403020100);
    load(128'h0F0E0D0C0B0A09080706050403020100, 0, 0, 16);
    chk("write_en", mem_en, 1);
    chk("write_mode", mem_mode, 1);
    @(posedge clk); #1;
    chk("after_write_busy", busy, 0);
    chk("after_write_en", mem_en, 0);
    rd(128'h0F0E0D0C0B0A09080706050403020100, 0, 1);

    // gapped load, backpressured readback
    wq.push_back(128'h1F1E1D1C1B1A19181716151413121110);
    load(128'h1F1E1D1C1B1A19181716151413121110, 1, 0, 16);
    @(posedge clk); #1;
    rd(128'h1F1E1D1C1B1A19181716151413121110, 1, 0);

    // rd_req and s_valid together in idle
    push_rd(128'h1F1E1D1C1B1A19181716151413121110);
    rd_ok = 1; rd_req = 1; s_valid = 1; s_data = 8'h77;
    @(negedge clk);
    chk("rd_prio_ready", s_ready, 0);
    @(posedge clk); #1;
    chk("rd_prio_en", mem_en, 1);
    chk("rd_prio_mode", mem_mode, 0);
    rd_req = 0; s_valid = 0;
    stream(0, n);
    rd_ok = 0;

    // rd_req during partial load is ignored
    wq.push_back(128'h2F2E2D2C2B2A29282726252423222120);
    load(128'h2F2E2D2C2B2A29282726252423222120, 0, 0, 5);
    rd_req = 1;
    load(128'h2F2E2D2C2B2A29282726252423222120, 0, 5, 16);
    rd_req = 0;
    chk("ign_rd_write_en", mem_en, 1);
    chk("ign_rd_write_mode", mem_mode, 1);
    @(posedge clk); #1;

    // capture window: memory presents A5 only in the WAIT cycle
    a5 = 1;
    rd({16{8'hA5}}, 0, 0);
    a5 = 0;

    // reset mid-load
    load(128'h3F3E3D3C3B3A39383736353433323130, 0, 0, 8);
    rst = 0;
    #1;
    chk("midload_busy", busy, 0);
    chk("midload_en", mem_en, 0);
    chk("midload_buf", mem_wdata, 0);
    #1 rst = 1;
    @(posedge clk); #1;
    wq.push_back({16{8'hFF}});
    load({16{8'hFF}}, 0, 0, 16);
    chk("ff_write_en", mem_en, 1);
    @(posedge clk); #1;

    // reset mid-send at cnt 7
    for (int i = 0; i < 7; i++) rq.push_back({1'b0, 8'hFF});
    rd_ok = 1; rd_req = 1;
    @(posedge clk); #1;
    rd_req = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    repeat (7) begin @(posedge clk); #1; end
    chk("send7_valid", m_valid, 1);
    rst = 0;
    #1;
    chk("midsend_valid", m_valid, 0);
    chk("midsend_data", m_data, 0);
    chk("midsend_busy", busy, 0);
    #1 rst = 1;
    rd_ok = 0;
    @(negedge clk);
    chk("post_reset_ready", s_ready, 1);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_valid", m_valid, 0);
    @(posedge clk); #1;
    chk("rq_drained", rq.size(), 0);
    chk("wq_drained", wq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
